// File: rtl/ser_byte_tx.sv
// Serial byte transmitter: valid/ready byte port into a small FIFO, each byte
// sent as a start(0) + 8 data (LSB first) + stop(1) frame, frames back to back.
// Ports: clk, reset (async, active-high); in_data/in_valid/in_ready push port;
// ser_out serial line (idles high); busy; tx_done (last stop-bit cycle);
// fifo_level occupancy 0..FIFO_DEPTH.
module ser_byte_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          ser_out,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_LVL  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   baud, baud_n;
  logic [2:0]      bit_cnt, bit_n;
  logic [7:0]      shreg, shreg_n;
  logic            ser_n;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            push, pop, full, empty, baud_end;

  assign full       = (count == FULL_LVL);
  assign empty      = (count == '0);
  assign in_ready   = !full;
  assign push       = in_valid && !full;
  assign baud_end   = (baud == BAUD_LAST);
  assign fifo_level = count;
  assign busy       = (state != IDLE) || !empty;
  assign tx_done    = (state == STOP) && baud_end;

  always_comb begin
    state_n = state;
    baud_n  = baud + CW'(1);
    bit_n   = bit_cnt;
    shreg_n = shreg;
    pop     = 1'b0;
    ser_n   = 1'b1;
    unique case (state)
      IDLE: begin
        baud_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = mem[rd_ptr];
          state_n = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_n  = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_n  = '0;
          shreg_n = {1'b0, shreg[7:1]};
          bit_n   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_n = '0;
          // Pop right here so the next start bit abuts this stop bit.
          if (!empty) begin
            pop     = 1'b1;
            shreg_n = mem[rd_ptr];
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Line value is registered from the next state so it tracks the FSM.
    unique case (state_n)
      START:   ser_n = 1'b0;
      DATA:    ser_n = shreg_n[0];
      default: ser_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      ser_out <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_cnt <= bit_n;
      shreg   <= shreg_n;
      ser_out <= ser_n;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        push && !pop: count <= count + (AW+1)'(1);
        pop && !push: count <= count - (AW+1)'(1);
        default:      count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_ser_byte_tx.sv
// Bench for ser_byte_tx: two instances (4 and 1 clocks per bit) checked
// every cycle against a frame-position model, plus a serial receiver.
module tb_ser_byte_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic [1:0] ser, rdy, bsy, done;
  logic [2:0] lvl0, lvl1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ser_byte_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u4 (
    .clk(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[0]), .ser_out(ser[0]), .busy(bsy[0]),
    .tx_done(done[0]), .fifo_level(lvl0)
  );

  ser_byte_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[1]), .ser_out(ser[1]), .busy(bsy[1]),
    .tx_done(done[1]), .fifo_level(lvl1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int cpb(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // Model: queue of bytes per instance plus position within current frame.
  logic [7:0] mq [2][$];
  bit         m_act [2];
  int         m_t [2];
  logic [7:0] m_b [2];
  logic [7:0] sent [$];
  int         acc0 = 0;

  initial forever begin
    int n;
    bit pp, pu;
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete();
        m_act[k] = 1'b0;
        m_t[k] = 0;
      end
      sent.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        n  = mq[k].size();
        pp = (n > 0) && (!m_act[k] || m_t[k] == 10 * cpb(k) - 1);
        pu = in_valid && (n < 4);
        if (m_act[k]) begin
          m_t[k]++;
          if (m_t[k] == 10 * cpb(k)) m_act[k] = 1'b0;
        end
        if (pp) begin
          m_b[k] = mq[k].pop_front();
          m_act[k] = 1'b1;
          m_t[k] = 0;
        end
        if (pu) begin
          mq[k].push_back(in_data);
          if (k == 0) begin
            sent.push_back(in_data);
            acc0++;
          end
        end
      end
    end
  end

  function automatic logic exp_ser(input int k);
    int c;
    c = cpb(k);
    if (!m_act[k]) return 1'b1;
    if (m_t[k] < c) return 1'b0;
    if (m_t[k] >= 9 * c) return 1'b1;
    return m_b[k][(m_t[k] - c) / c];
  endfunction

  function automatic logic [2:0] lvl(input int k);
    return (k == 0) ? lvl0 : lvl1;
  endfunction

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ser_out[%0d]", k), ser[k], exp_ser(k));
      chk($sformatf("tx_done[%0d]", k), done[k],
          m_act[k] && (m_t[k] == 10 * cpb(k) - 1));
      chk($sformatf("busy[%0d]", k), bsy[k],
          m_act[k] || (mq[k].size() > 0));
      chk($sformatf("fifo_level[%0d]", k), lvl(k), mq[k].size());
      chk($sformatf("in_ready[%0d]", k), rdy[k], mq[k].size() < 4);
    end
  end

  // Serial receiver on the 4-clock line, sampling mid-bit.
  bit         rx_on = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_b = 8'h00;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (ser[0] == 1'b0) begin
        rx_on = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == 2) chk("rx_start", ser[0], 0);
      if (rx_cnt >= 6 && rx_cnt <= 34 && rx_cnt % 4 == 2)
        rx_b[(rx_cnt - 6) / 4] = ser[0];
      if (rx_cnt == 38) begin
        chk("rx_stop", ser[0], 1);
        chk("rx_byte_expected", sent.size() > 0, 1);
        if (sent.size() > 0) chk("rx_byte", rx_b, sent.pop_front());
        rx_on = 1'b0;
      end
    end
  end

  task automatic push(input logic [7:0] d);
    bit acc;
    acc = 1'b0;
    in_data = d;
    in_valid = 1'b1;
    for (int g = 0; g < 2000 && !acc; g++) begin
      acc = rdy[0];
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
    chk("push_accepted", acc, 1);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (bsy != 2'b00 && g < 3000) begin
      @(posedge clk);
      #2;
      g++;
    end
    chk("idle_reached", bsy, 0);
  endtask

  task automatic wait_done0();
    int g;
    g = 0;
    while (!done[0] && g < 500) begin
      @(posedge clk);
      #2;
      g++;
    end
    chk("tx_done_seen", done[0], 1);
  endtask

  initial begin
    logic [9:0] pat;
    logic [7:0] b2b [5];
    int pulses, zeros, first_after, base, cyc_n;
    bit dense;
    int cyc [$];

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ser_out", ser[0], 1);
    chk("rst_in_ready", rdy[0], 1);
    chk("rst_fifo_level", lvl0, 0);
    chk("rst_busy", bsy[0], 0);
    chk("rst_tx_done", done[0], 0);
    rst = 1'b0;
    @(posedge clk);
    #2;

    // Single byte 0xA5 at 4 clocks per bit.
    pat = 10'b1101001010;
    push(8'hA5);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #2;
      chk("a5_bit", ser[0], pat[i / 4]);
      if (done[0]) begin
        pulses++;
        chk("a5_done_cycle", i, 39);
        chk("a5_busy_hi", bsy[0], 1);
      end
    end
    chk("a5_pulses", pulses, 1);
    @(posedge clk);
    #2;
    chk("a5_busy_fall", bsy[0], 0);

    // Single byte 0x5A at 1 clock per bit.
    wait_idle();
    pat = 10'b1010110100;
    push(8'h5A);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      chk("c1_bit", ser[1], pat[i]);
    end

    // Back-to-back, filling the FIFO.
    wait_idle();
    b2b = '{8'h00, 8'hFF, 8'h3C, 8'hC3, 8'h81};
    foreach (b2b[j]) push(b2b[j]);
    chk("full_ready_low", rdy[0], 0);
    chk("full_level", lvl0, 4);
    first_after = -1;
    cyc.delete();
    for (int i = 0; i < 400 && cyc.size() < 5; i++) begin
      @(posedge clk);
      #2;
      if (cyc.size() == 1 && first_after < 0) begin
        first_after = i;
        chk("ready_after_pop", rdy[0], 1);
      end
      if (done[0]) begin
        if (cyc.size() == 0) chk("ready_low_until_pop", rdy[0], 0);
        cyc.push_back(i);
      end
    end
    chk("b2b_pulses", cyc.size(), 5);
    for (int j = 1; j < cyc.size(); j++)
      chk("b2b_spacing", cyc[j] - cyc[j-1], 40);

    // Push in the same cycle as the stop-to-start pop.
    wait_idle();
    push(8'h11);
    push(8'h22);
    wait_done0();
    chk("coinc_level_before", lvl0, 1);
    in_data = 8'h33;
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    chk("coinc_level_after", lvl0, 1);

    // Reset during data bit 3 of the second queued byte.
    wait_idle();
    push(8'h96);
    push(8'h61);
    push(8'hF0);
    wait_done0();
    repeat (18) @(posedge clk);
    #2;
    chk("pre_reset_bit3", ser[0], 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ser_out", ser[0], 1);
    chk("mid_rst_level", lvl0, 0);
    chk("mid_rst_ready", rdy[0], 1);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    zeros = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #2;
      if (!ser[0]) zeros++;
    end
    chk("quiet_zeros", zeros, 0);
    chk("quiet_busy", bsy[0], 0);
    push(8'h4B);
    wait_idle();

    // Randomised traffic with dense and sparse stretches.
    base = acc0;
    cyc_n = 0;
    dense = 1'b1;
    while (acc0 - base < 1000 && cyc_n < 70000) begin
      if (cyc_n % 200 == 0) dense = ($urandom_range(0, 4) != 0);
      in_valid = dense ? ($urandom_range(0, 19) == 0)
                       : ($urandom_range(0, 59) == 0);
      in_data = 8'($urandom);
      @(posedge clk);
      #2;
      cyc_n++;
    end
    in_valid = 1'b0;
    chk("random_bytes", acc0 - base >= 1000, 1);
    wait_idle();
    repeat (2) @(posedge clk);
    #2;
    chk("sent_drained", sent.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ser_byte_tx.md
# ser_byte_tx

Host-side serial byte transmitter that drives the single-wire `ser_data` input of the MLP accelerator, directly upstream of its deserializer. It accepts image and weight bytes from a local producer through a valid/ready port, buffers them in a small FIFO, and shifts each one out as a framed serial word. Frames follow one another with no idle gap, so a producer that keeps the FIFO filled holds the link at full rate.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit. Legal range is ≥1.
- `FIFO_DEPTH`, default 4: byte FIFO entries. Must be a power of 2 and ≥2.

Ports:
- `clk`  input  1  single clock; all logic rising-edge.
- `reset`  input  1  asynchronous, active-high reset.
- `in_data`  input  8  byte to transmit.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  FIFO can accept a byte; equals `!full`.
- `ser_out`  output  1  serial line, connects to the accelerator's `ser_data`. Idles high.
- `busy`  output  1  high when the FSM is not in IDLE or the FIFO is non-empty.
- `tx_done`  output  1  one-cycle pulse in the last cycle of each stop bit.
- `fifo_level`  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH.

## Operation
- Frame format, in order:
  - start bit 0;
  - 8 data bits, LSB first;
  - stop bit 1.
  - Each bit lasts exactly `CLKS_PER_BIT` cycles, so a frame is 10·`CLKS_PER_BIT` cycles.
- Push: a byte is written when `in_valid && in_ready` at a rising edge.
- Full FIFO: `in_ready`=0. No push can occur in that cycle, even if a pop happens in the same cycle.
- FSM states:
  - IDLE: `ser_out`=1. If the FIFO is non-empty, pop the head into an 8-bit shift register and go to START.
  - START: `ser_out`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `ser_out`=shreg[0]. Every `CLKS_PER_BIT` cycles, shift right and increment a 3-bit bit counter. After bit 7 completes, go to STOP.
  - STOP: `ser_out`=1 for `CLKS_PER_BIT` cycles. `tx_done`=1 in the final cycle. At the end of STOP:
    - FIFO non-empty: pop in the same cycle and go directly to START (no idle cycle).
    - Otherwise: go to IDLE.
- Counters:
  - The baud counter counts 0..`CLKS_PER_BIT`-1 and is cleared on every state change.
  - With `CLKS_PER_BIT`=1, every bit is a single cycle.
- Simultaneous push and pop (FIFO not full): `fifo_level` stays unchanged and ordering is preserved.
- FIFO pointers wrap modulo `FIFO_DEPTH`. Occupancy is tracked by an explicit counter, not pointer compare.
- `ser_out` is driven from a flop, so the line is glitch-free.

## Timing
- Reset values:
  - `ser_out`=1, `busy`=0, `tx_done`=0, `fifo_level`=0.
  - `in_ready`=1 (FIFO empty).
  - FSM in IDLE; FIFO pointers, counters and shift register cleared.
- Reset mid-frame: `ser_out` returns to 1 immediately (asynchronous). FIFO contents are discarded. No partial frame resumes after release.
- Latency:
  - Byte pushed at edge E0 into an empty, idle block: popped at E1.
  - `ser_out` falls after E1.
  - The start bit occupies cycles E1..E1+`CLKS_PER_BIT`-1.
- `fifo_level` updates one edge after a push or pop. `in_ready` is combinational from the level.
- `busy` falls in the cycle after the last `tx_done` when the FIFO is empty.
- Back-to-back: consecutive frames abut. The stop bit of frame k is immediately followed by the start bit of frame k+1.

## Test plan
- Reset and single byte: hold `reset`, then release it. Check the reset values (`ser_out`=1, `in_ready`=1, `fifo_level`=0). With `CLKS_PER_BIT`=4, push 0xA5. Required `ser_out` sequence: 0, then bits 1,0,1,0,0,1,0,1, then 1, each 4 cycles. Exactly one `tx_done` pulse, 40 cycles after the start bit begins. `busy` falls the cycle after `tx_done`.
- Back-to-back and full: push 0x00, 0xFF, 0x3C, 0xC3, 0x81 on consecutive cycles with `FIFO_DEPTH`=4.
  - `in_ready` drops while the FIFO is full and reads 1 again after the next pop.
  - All five frames are received in order with no gap between stop and start bits.
  - `tx_done` pulses 5 times, 40 cycles apart.
- Push/pop coincidence: push a byte in the exact cycle the STOP→START pop occurs. `fifo_level` is unchanged and the byte order is intact.
- `CLKS_PER_BIT`=1: push 0x5A. The 10-cycle frame is 0,0,1,0,1,1,0,1,0,1.
- Reset mid-frame: assert `reset` during DATA bit 3 of the second of three queued bytes.
  - `ser_out`=1 immediately and `fifo_level`=0.
  - After release, no bits are emitted until a new push, which then transmits correctly.
- Randomised: random bytes with random `in_valid` gaps. A scoreboard serial receiver checks every byte and frame timing over 1000 bytes.
